// File: rtl/uart2fifo.sv
// uart2fifo: forwards a fixed-length frame of UART bytes into a downstream FIFO.
// Define UART2FIFO_TIMEOUT_EN to end the frame with an error after TIMEOUT_CYC idle cycles.
module uart2fifo #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fs,
    output logic       fd,
    input  logic [7:0] data_len,
    input  logic       uart_rxdv,
    input  logic [7:0] uart_rxd,
    input  logic       fifo_full,
    output logic       fifo_txen,
    output logic [7:0] fifo_txd,
    output logic [7:0] rx_cnt,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, WORK, LAST} state_t;
    state_t     state_q;
    logic [7:0] len_q, cnt_q, txd_q;
    logic       txen_q, err_q;
    logic       take_d, tmo_hit_d;
    logic [7:0] cnt_d;
    // a byte is only counted while the frame still has room, so cnt_q never passes len_q
    assign take_d = (state_q == WORK) && uart_rxdv && (cnt_q != len_q);
    assign cnt_d  = cnt_q + 8'd1;
`ifdef UART2FIFO_TIMEOUT_EN
    logic [15:0] tmo_q;
    assign tmo_hit_d = (tmo_q == TIMEOUT_CYC);
`else
    logic unused_tmo;
    assign tmo_hit_d  = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYC;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= 8'h00;
            cnt_q   <= 8'h00;
            txd_q   <= 8'h00;
            txen_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART2FIFO_TIMEOUT_EN
            tmo_q   <= 16'd0;
`endif
        end else begin
            txen_q <= 1'b0;
            if (take_d) begin
                cnt_q  <= cnt_d;
                txen_q <= !fifo_full;
                if (!fifo_full) txd_q <= uart_rxd;
                else err_q <= 1'b1;
            end
`ifdef UART2FIFO_TIMEOUT_EN
            tmo_q <= (state_q == WORK && !uart_rxdv) ? tmo_q + 16'd1 : 16'd0;
`endif
            case (state_q)
                IDLE: if (fs) begin
                    state_q <= WORK;
                    len_q   <= data_len;
                    cnt_q   <= 8'h00;
                    err_q   <= 1'b0;
                end
                WORK: if (!fs) state_q <= IDLE;
                    else if (cnt_q == len_q) state_q <= LAST;
                    else if (tmo_hit_d) begin
                        state_q <= LAST;
                        err_q   <= 1'b1;
                    end
                LAST: if (!fs) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign fd        = (state_q == LAST);
    assign fifo_txen = txen_q;
    assign fifo_txd  = txd_q;
    assign rx_cnt    = cnt_q;
    assign err       = err_q;
endmodule

// File: tb/tb_uart2fifo.sv
// tb_uart2fifo: directed frames; written bytes are checked against an expected-byte queue.
module tb_uart2fifo;
    logic       clk = 1'b0, rst = 1'b0, fs = 1'b0, uart_rxdv = 1'b0, fifo_full = 1'b0;
    logic [7:0] data_len = 8'h00, uart_rxd = 8'h00;
    logic       fd, fifo_txen, err;
    logic [7:0] fifo_txd, rx_cnt;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         errors = 0, checks = 0;

    uart2fifo #(.TIMEOUT_CYC(16'd20)) dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd), .data_len(data_len),
        .uart_rxdv(uart_rxdv), .uart_rxd(uart_rxd), .fifo_full(fifo_full),
        .fifo_txen(fifo_txen), .fifo_txd(fifo_txd), .rx_cnt(rx_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic full, input logic wr);
        @(posedge clk);
        #1;
        uart_rxdv = 1'b1;
        uart_rxd  = b;
        fifo_full = full;
        if (wr) exp_q.push_back(b);
        @(posedge clk);
        #1;
        uart_rxdv = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic start(input logic [7:0] len);
        data_len = len;
        fs = 1'b1;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (fifo_txen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got fifo_txd=%0h expected no write at %0t", fifo_txd, $time);
            end else begin
                e = exp_q.pop_front();
                chk("fifo_txd", {24'd0, fifo_txd}, {24'd0, e});
            end
        end
    end

    initial begin
        #3;
        chk("rst_fd", {31'd0, fd}, 0);
        chk("rst_txen", {31'd0, fifo_txen}, 0);
        chk("rst_txd", {24'd0, fifo_txd}, 0);
        chk("rst_cnt", {24'd0, rx_cnt}, 0);
        chk("rst_err", {31'd0, err}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(2);
        chk("idle_fd", {31'd0, fd}, 0);

        // normal frame, data_len changed mid-frame must be ignored
        start(8'd4);
        data_len = 8'd99;
        for (int i = 0; i < 4; i++) begin
            tick(9);
            send(8'hA1 + 8'(i), 1'b0, 1'b1);
        end
        chk("f1_cnt", {24'd0, rx_cnt}, 4);
        chk("f1_fd_early", {31'd0, fd}, 0);
        tick(1);
        chk("f1_fd", {31'd0, fd}, 1);
        chk("f1_err", {31'd0, err}, 0);
        send(8'hEE, 1'b0, 1'b0);
        chk("f1_last_ignore", {24'd0, rx_cnt}, 4);
        fs = 1'b0;
        tick(1);
        chk("f1_fd_off", {31'd0, fd}, 0);

        // overflow on the second byte
        start(8'd3);
        send(8'hB1, 1'b0, 1'b1);
        send(8'hB2, 1'b1, 1'b0);
        chk("f2_err_mid", {31'd0, err}, 1);
        send(8'hB3, 1'b0, 1'b1);
        chk("f2_cnt", {24'd0, rx_cnt}, 3);
        tick(1);
        chk("f2_fd", {31'd0, fd}, 1);
        chk("f2_err", {31'd0, err}, 1);
        fs = 1'b0;
        tick(1);

        // zero-length frame
        start(8'd0);
        chk("f3_fd_work", {31'd0, fd}, 0);
        chk("f3_err_clr", {31'd0, err}, 0);
        tick(1);
        chk("f3_fd", {31'd0, fd}, 1);
        chk("f3_cnt", {24'd0, rx_cnt}, 0);
        fs = 1'b0;
        tick(1);
        chk("f3_fd_off", {31'd0, fd}, 0);

        // async reset mid-frame, then a clean frame
        start(8'd5);
        send(8'h11, 1'b0, 1'b1);
        send(8'h12, 1'b0, 1'b1);
        tick(1);
        #2 rst = 1'b0;
        fs = 1'b0;
        #1;
        chk("r_fd", {31'd0, fd}, 0);
        chk("r_txen", {31'd0, fifo_txen}, 0);
        chk("r_txd", {24'd0, fifo_txd}, 0);
        chk("r_cnt", {24'd0, rx_cnt}, 0);
        chk("r_err", {31'd0, err}, 0);
        tick(2);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(1);
        start(8'd2);
        send(8'h21, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        tick(1);
        chk("r2_fd", {31'd0, fd}, 1);
        chk("r2_cnt", {24'd0, rx_cnt}, 2);
        fs = 1'b0;
        tick(1);

        // abort keeps count; bytes in IDLE ignored
        start(8'd3);
        send(8'h31, 1'b0, 1'b1);
        fs = 1'b0;
        tick(1);
        chk("ab_fd", {31'd0, fd}, 0);
        chk("ab_cnt", {24'd0, rx_cnt}, 1);
        send(8'h32, 1'b0, 1'b0);
        tick(3);
        chk("ab_idle_cnt", {24'd0, rx_cnt}, 1);
        chk("ab_idle_fd", {31'd0, fd}, 0);

        // abort on the same cycle as the final byte
        start(8'd1);
        uart_rxdv = 1'b1;
        uart_rxd  = 8'h41;
        fs = 1'b0;
        exp_q.push_back(8'h41);
        tick(1);
        uart_rxdv = 1'b0;
        chk("abf_cnt", {24'd0, rx_cnt}, 1);
        tick(1);
        chk("abf_fd", {31'd0, fd}, 0);

        // starved frame: timeout build ends it, default build waits
        start(8'd4);
        send(8'h51, 1'b0, 1'b1);
        tick(30);
`ifdef UART2FIFO_TIMEOUT_EN
        chk("to_fd", {31'd0, fd}, 1);
        chk("to_err", {31'd0, err}, 1);
`else
        chk("to_fd", {31'd0, fd}, 0);
        chk("to_err", {31'd0, err}, 0);
`endif
        chk("to_cnt", {24'd0, rx_cnt}, 1);
        fs = 1'b0;
        tick(1);

        // maximum length, extra byte must not push the counter past 255
        start(8'd255);
        for (int i = 0; i < 255; i++) send(8'(i), 1'b0, 1'b1);
        chk("max_cnt", {24'd0, rx_cnt}, 255);
        chk("max_fd_early", {31'd0, fd}, 0);
        send(8'h77, 1'b0, 1'b0);
        chk("max_cnt_hold", {24'd0, rx_cnt}, 255);
        chk("max_fd", {31'd0, fd}, 1);
        fs = 1'b0;
        tick(3);
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
